bin2bcd_8digit: RTL and testbench



---
 rtl/bin2bcd_8digit.sv | 130 +++++++++++++
 tb/tb_bin2bcd_8digit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_8digit.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) for the
// 8-digit display driver. Saturates to 99999999 and flags overflow.
module bin2bcd_8digit #(
  parameter int BIN_WIDTH = 27,
  parameter bit BLANK_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIN_WIDTH-1:0] bin_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [31:0]          digits,
  output logic [7:0]           blank_mask,
  output logic                 overflow,
  output logic                 out_valid
);

  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int SW = 32 + BIN_WIDTH;
  localparam logic [7:0]  BLANK_RST = BLANK_EN ? 8'hFE : 8'h00;
  localparam logic [31:0] MAX_DEC   = 32'd99_999_999;
  localparam logic [31:0] SAT_BCD   = 32'h9999_9999;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CONV = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state_r;
  logic [SW-1:0]   shift_r;
  logic [CW-1:0]   cnt_r;
  logic            ovf_pending_r;
  logic [31:0]     adj_s;
  logic [SW-1:0]   shift_next_s;
  logic [31:0]     result_s;
  logic            ovf_in_s;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [31:0] dabble_adjust(input logic [31:0] bcd);
    logic [31:0] res;
    logic [3:0]  nib;
    res = 32'h0;
    for (int i = 0; i < 8; i++) begin
      nib = bcd[4*i +: 4];
      if (nib >= 4'd5) begin
        res[4*i +: 4] = nib + 4'd3;
      end else begin
        res[4*i +: 4] = nib;
      end
    end
    return res;
  endfunction

  // Digit 0 is never blanked so that zero still shows a single "0".
  function automatic logic [7:0] lead_zero_mask(input logic [31:0] d);
    logic [7:0] mask;
    mask = 8'h00;
    for (int i = 1; i < 8; i++) begin
      if (BLANK_EN && ((d >> (4*i)) == 32'h0)) begin
        mask[i] = 1'b1;
      end else begin
        mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

  assign in_ready = (state_r == IDLE);

  // One double-dabble step, the saturated result and the overflow compare.
  always_comb begin
    adj_s        = dabble_adjust(shift_r[SW-1:BIN_WIDTH]);
    shift_next_s = {adj_s, shift_r[BIN_WIDTH-1:0]} << 1;
    ovf_in_s     = ({{(32-BIN_WIDTH){1'b0}}, bin_in} > MAX_DEC);
    if (ovf_pending_r) begin
      result_s = SAT_BCD;
    end else begin
      result_s = shift_r[SW-1:BIN_WIDTH];
    end
  end

  // Conversion FSM with the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      shift_r       <= '0;
      cnt_r         <= '0;
      ovf_pending_r <= 1'b0;
      digits        <= 32'h0;
      blank_mask    <= BLANK_RST;
      overflow      <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            shift_r       <= {32'h0, bin_in};
            cnt_r         <= '0;
            ovf_pending_r <= ovf_in_s;
            state_r       <= CONV;
          end else begin
            state_r <= IDLE;
          end
        end
        CONV: begin
          shift_r <= shift_next_s;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == CW'(BIN_WIDTH - 1)) begin
            state_r <= DONE;
          end else begin
            state_r <= CONV;
          end
        end
        DONE: begin
          digits     <= result_s;
          overflow   <= ovf_pending_r;
          blank_mask <= lead_zero_mask(result_s);
          out_valid  <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_8digit.sv
// Scoreboard bench: a default instance (27 bits, blanking on) and a narrow
// instance (8 bits, blanking off) checked against an arithmetic reference model.
module tb_bin2bcd_8digit;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  m;
    logic        o;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [26:0] bin_a;
  logic        vld_a, rdy_a, ovf_a, ov_a;
  logic [31:0] dig_a;
  logic [7:0]  msk_a;
  logic [7:0]  bin_b;
  logic        vld_b, rdy_b, ovf_b, ov_b;
  logic [31:0] dig_b;
  logic [7:0]  msk_b;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   busy_a = 0;
  int   busy_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  bin2bcd_8digit dut_a (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_a), .in_valid(vld_a), .in_ready(rdy_a),
    .digits(dig_a), .blank_mask(msk_a), .overflow(ovf_a), .out_valid(ov_a)
  );

  bin2bcd_8digit #(.BIN_WIDTH(8), .BLANK_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_b), .in_valid(vld_b), .in_ready(rdy_b),
    .digits(dig_b), .blank_mask(msk_b), .overflow(ovf_b), .out_valid(ov_b)
  );

  // Reference: decimal digits by repeated division, blanking by magnitude.
  function automatic exp_t model(input longint unsigned v, input bit blank_en);
    exp_t e;
    longint unsigned t, p;
    e.o = (v > 64'd99_999_999);
    e.d = 32'h0;
    e.m = 8'h00;
    e.due = 0;
    if (e.o) begin
      e.d = 32'h9999_9999;
    end else begin
      t = v;
      for (int i = 0; i < 8; i++) begin
        e.d[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
      p = 1;
      for (int i = 1; i < 8; i++) begin
        p = p * 10;
        if (blank_en && v < p) e.m[i] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Handshake model: records the expected result and its due cycle at each accept.
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      busy_a <= 0;
      busy_b <= 0;
      q_a.delete();
      q_b.delete();
    end else begin
      cyc <= cyc + 1;
      if (busy_a == 0 && vld_a) begin
        e = model(64'(bin_a), 1'b1);
        e.due = cyc + 29;
        q_a.push_back(e);
        busy_a <= 28;
      end else if (busy_a > 0) begin
        busy_a <= busy_a - 1;
      end
      if (busy_b == 0 && vld_b) begin
        e = model(64'(bin_b), 1'b0);
        e.due = cyc + 10;
        q_b.push_back(e);
        busy_b <= 9;
      end else if (busy_b > 0) begin
        busy_b <= busy_b - 1;
      end
    end
  end

  // Monitor: out_valid must appear exactly on the due cycle with the model's result.
  always @(negedge clk) begin
    exp_t e;
    logic exp_ov;
    if (rst_n) begin
      chk("in_ready_a", rdy_a, busy_a == 0);
      chk("in_ready_b", rdy_b, busy_b == 0);
      exp_ov = (q_a.size() > 0) && (q_a[0].due == cyc);
      chk("out_valid_a", ov_a, exp_ov);
      if (exp_ov) begin
        e = q_a.pop_front();
        chk("digits_a", dig_a, e.d);
        chk("blank_a", msk_a, e.m);
        chk("overflow_a", ovf_a, e.o);
      end
      exp_ov = (q_b.size() > 0) && (q_b[0].due == cyc);
      chk("out_valid_b", ov_b, exp_ov);
      if (exp_ov) begin
        e = q_b.pop_front();
        chk("digits_b", dig_b, e.d);
        chk("blank_b", msk_b, e.m);
        chk("overflow_b", ovf_b, e.o);
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_digits_a", dig_a, 32'h0);
    chk("rst_blank_a", msk_a, 8'hFE);
    chk("rst_overflow_a", ovf_a, 1'b0);
    chk("rst_out_valid_a", ov_a, 1'b0);
    chk("rst_in_ready_a", rdy_a, 1'b1);
    chk("rst_digits_b", dig_b, 32'h0);
    chk("rst_blank_b", msk_b, 8'h00);
    chk("rst_out_valid_b", ov_b, 1'b0);
  endtask

  task automatic send_a(input logic [26:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_a) chk("ready_timeout_a", rdy_a, 1'b1);
    bin_a = v;
    vld_a = 1'b1;
    @(negedge clk);
    vld_a = 1'b0;
    bin_a = 27'($urandom);
  endtask

  task automatic send_b(input logic [7:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_b) chk("ready_timeout_b", rdy_b, 1'b1);
    bin_b = v;
    vld_b = 1'b1;
    @(negedge clk);
    vld_b = 1'b0;
    bin_b = 8'($urandom);
  endtask

  function automatic logic [26:0] pick();
    case ($urandom_range(0, 3))
      0: return 27'($urandom_range(0, 999));
      1: return 27'($urandom_range(0, 99_999_999));
      2: return 27'($urandom);
      default: return 27'($urandom_range(99_999_990, 100_000_010));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    vld_a = 1'b0;
    vld_b = 1'b0;
    bin_a = 27'h0;
    bin_b = 8'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    send_a(27'd12_345_678);
    send_a(27'd42);
    send_a(27'd0);
    send_a(27'd99_999_999);
    send_a(27'd100_000_000);
    send_a(27'h7FF_FFFF);
    for (int i = 0; i < 30; i++) begin
      send_a(pick());
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // in_valid held high while bin_in changes every cycle
    repeat (40) @(negedge clk);
    vld_a = 1'b1;
    for (int i = 0; i < 120; i++) begin
      bin_a = pick();
      @(negedge clk);
    end
    vld_a = 1'b0;

    // reset in the middle of converting 555
    repeat (40) @(negedge clk);
    send_a(27'd555);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #2 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    send_a(27'd7);

    send_b(8'd255);
    send_b(8'd0);
    for (int i = 0; i < 15; i++) begin
      send_b(8'($urandom));
    end

    repeat (40) @(negedge clk);
    chk("drain_a", 64'(q_a.size()), 64'd0);
    chk("drain_b", 64'(q_b.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
